// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: end-of-program marker and loader state.
package program_loader_pkg;

    // Word that terminates the program image; never written to instruction memory.
    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

    // LOAD packs bytes into instruction words; RUN feeds bytes to the CPU input FIFO.
    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } loader_state_e;

endpackage

// File: rtl/program_loader_byte_fifo.sv
// Byte FIFO with first-word-fall-through head and wrap-bit pointers.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module program_loader_byte_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_push,
    input  logic [7:0] i_push_data,
    input  logic       i_pop,
    output logic [7:0] o_head,
    output logic       o_empty,
    output logic       o_full
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]          r_mem [DEPTH];
    logic [DEPTH_LOG2:0] r_wr_ptr;
    logic [DEPTH_LOG2:0] r_rd_ptr;
    // Last byte popped; shown on the head output while the FIFO is empty.
    logic [7:0]          r_last;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop_ok;
    logic                  w_push_ok;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [DEPTH_LOG2-1:0] w_rd_idx;

    assign w_wr_idx = r_wr_ptr[DEPTH_LOG2-1:0];
    assign w_rd_idx = r_rd_ptr[DEPTH_LOG2-1:0];

    // Equal pointers mean empty; same index with differing wrap bit means full.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) && (w_wr_idx == w_rd_idx);

    assign w_pop_ok  = i_pop && !w_empty;
    // On a full FIFO the popped slot is exactly the slot being written.
    assign w_push_ok = i_push && (!w_full || w_pop_ok);

    // Pointer and last-popped-byte registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_last   <= 8'h00;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + {{DEPTH_LOG2{1'b0}}, 1'b1};
                r_last   <= r_mem[w_rd_idx];
            end
        end
    end

    // Storage array; contents are only observable once written, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

    assign o_head  = w_empty ? r_last : r_mem[w_rd_idx];
    assign o_empty = w_empty;
    assign o_full  = w_full;

endmodule

// File: rtl/program_loader.sv
// Program loader: packs received bytes big-endian into instruction words during load,
// releases the CPU on the end marker, then buffers further bytes as program input.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned IMEM_ADDR_W     = 14,
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [7:0]             i_rx_data,
    input  logic                   i_rx_changed,
    output logic                   o_imem_we,
    output logic [IMEM_ADDR_W-1:0] o_imem_addr,
    output logic [31:0]            o_imem_wdata,
    output logic                   o_loaded,
    output logic                   o_load_error,
    input  logic                   i_rd_en,
    output logic [7:0]             o_rd_data,
    output logic                   o_rd_empty,
    output logic                   o_fifo_overflow
);

    // One extra bit so the word address can sit at capacity without wrapping.
    localparam int unsigned CAP_W = IMEM_ADDR_W + 1;
    localparam logic [CAP_W-1:0] CAPACITY = {1'b1, {IMEM_ADDR_W{1'b0}}};

    loader_state_e          r_state;
    logic [23:0]            r_shift;
    logic [1:0]             r_byte_cnt;
    logic [CAP_W-1:0]       r_word_addr;
    logic                   r_imem_we;
    logic [IMEM_ADDR_W-1:0] r_imem_addr;
    logic [31:0]            r_imem_wdata;
    logic                   r_loaded;
    logic                   r_load_error;
    logic                   r_fifo_overflow;

    loader_state_e          w_state_next;
    logic [23:0]            w_shift_next;
    logic [1:0]             w_byte_cnt_next;
    logic [CAP_W-1:0]       w_word_addr_next;
    logic                   w_imem_we_next;
    logic [IMEM_ADDR_W-1:0] w_imem_addr_next;
    logic [31:0]            w_imem_wdata_next;
    logic                   w_loaded_next;
    logic                   w_load_error_next;
    logic                   w_fifo_overflow_next;

    logic [31:0] w_word;
    logic        w_fifo_push;
    logic        w_fifo_pop;
    logic [7:0]  w_fifo_head;
    logic        w_fifo_empty;
    logic        w_fifo_full;

    // Word as it stands once the current byte is shifted in.
    assign w_word = {r_shift, i_rx_data};

    // The FIFO only sees traffic after the program has been released.
    assign w_fifo_push = (r_state == RUN) && i_rx_changed;
    assign w_fifo_pop  = (r_state == RUN) && i_rd_en;

    program_loader_byte_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (w_fifo_push),
        .i_push_data (i_rx_data),
        .i_pop       (w_fifo_pop),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full)
    );

    // Next-state logic: word packing and memory writes in LOAD, overflow tracking in RUN.
    always_comb begin
        w_state_next         = r_state;
        w_shift_next         = r_shift;
        w_byte_cnt_next      = r_byte_cnt;
        w_word_addr_next     = r_word_addr;
        w_imem_we_next       = 1'b0;
        w_imem_addr_next     = r_imem_addr;
        w_imem_wdata_next    = r_imem_wdata;
        w_loaded_next        = r_loaded;
        w_load_error_next    = r_load_error;
        w_fifo_overflow_next = r_fifo_overflow;

        unique case (r_state)
            LOAD: begin
                if (i_rx_changed) begin
                    w_shift_next    = w_word[23:0];
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        if (w_word == END_MARKER) begin
                            w_state_next    = RUN;
                            w_loaded_next   = 1'b1;
                            w_byte_cnt_next = 2'd0;
                        end else if (r_word_addr != CAPACITY) begin
                            w_imem_we_next    = 1'b1;
                            w_imem_addr_next  = r_word_addr[IMEM_ADDR_W-1:0];
                            w_imem_wdata_next = w_word;
                            w_word_addr_next  = r_word_addr + {{IMEM_ADDR_W{1'b0}}, 1'b1};
                        end else begin
                            // Memory full: drop the word, keep loading until the marker.
                            w_load_error_next = 1'b1;
                        end
                    end
                end
            end
            RUN: begin
                // A byte is lost only if the FIFO is full and no pop frees a slot this cycle.
                if (i_rx_changed && w_fifo_full && !(i_rd_en && !w_fifo_empty)) begin
                    w_fifo_overflow_next = 1'b1;
                end
            end
        endcase
    end

    // State register and all loader registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state         <= LOAD;
            r_shift         <= 24'h0;
            r_byte_cnt      <= 2'd0;
            r_word_addr     <= '0;
            r_imem_we       <= 1'b0;
            r_imem_addr     <= '0;
            r_imem_wdata    <= 32'h0;
            r_loaded        <= 1'b0;
            r_load_error    <= 1'b0;
            r_fifo_overflow <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_shift         <= w_shift_next;
            r_byte_cnt      <= w_byte_cnt_next;
            r_word_addr     <= w_word_addr_next;
            r_imem_we       <= w_imem_we_next;
            r_imem_addr     <= w_imem_addr_next;
            r_imem_wdata    <= w_imem_wdata_next;
            r_loaded        <= w_loaded_next;
            r_load_error    <= w_load_error_next;
            r_fifo_overflow <= w_fifo_overflow_next;
        end
    end

    assign o_imem_we       = r_imem_we;
    assign o_imem_addr     = r_imem_addr;
    assign o_imem_wdata    = r_imem_wdata;
    assign o_loaded        = r_loaded;
    assign o_load_error    = r_load_error;
    assign o_rd_data       = w_fifo_head;
    assign o_rd_empty      = w_fifo_empty;
    assign o_fifo_overflow = r_fifo_overflow;

endmodule
